foc_mul_pipe: RTL and testbench

Parametrised, multi-stage pipelined multiplier for the FOC datapath. It computes a·b with independently configurable operand signedness and Q-format output scaling (round-half-up right shift, then saturation to the output width). It carries a valid/ready handshake with whole-pipeline stall and a sideband tag. Used wherever the FOC controller scales currents and voltages by gains or trig terms and needs a narrowed, saturated result instead of a raw full-width product.

---
 rtl/foc_mul_pipe.sv | 144 ++++++++++++++
 tb/tb_foc_mul_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/foc_mul_pipe.sv
// foc_mul_pipe: STAGES-deep pipelined multiplier a*b with per-operand
// signedness, round-half-up right shift by SHIFT, and output narrowing.
// Valid/ready with whole-pipeline stall and a sideband tag.
// Optional feature macro FOC_MUL_SAT_EN: when defined the shifted value is
// clamped to OUT_WIDTH and sat/sat_count report it; when undefined the value
// wraps to its low OUT_WIDTH bits and sat/sat_count read 0.
module foc_mul_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 17,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int STAGES    = 4,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 18,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] p,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 sat,
  output logic [15:0]          sat_count,
  input  logic                 sat_clr
);

  localparam int P = A_WIDTH + B_WIDTH + 2;
  localparam bit OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  // P+1 bits so adding the rounding constant can never overflow
  localparam logic signed [P:0] ONE   = (P+1)'(1);
  localparam logic signed [P:0] RND   = (ONE <<< SHIFT) >>> 1;
  localparam logic signed [P:0] S_MAX = (ONE <<< (OUT_WIDTH-1)) - ONE;
  localparam logic signed [P:0] S_MIN = -(ONE <<< (OUT_WIDTH-1));
  localparam logic signed [P:0] U_MAX = (ONE <<< OUT_WIDTH) - ONE;

  logic                 adv;
  logic [STAGES:1]      vld_pipe;
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic signed [P-1:0]  prod_pipe [2:STAGES-1];
  logic [TAG_WIDTH-1:0] tag_pipe  [1:STAGES-1];

  logic signed [A_WIDTH:0] a_x;
  logic signed [B_WIDTH:0] b_x;
  logic signed [P-1:0]     a_e, b_e, prod_c;
  logic signed [P:0]       rnd_c, shf_c;
  logic [OUT_WIDTH-1:0]    p_c;
  logic                    sat_c;

  // A full output register that is not being drained stalls everything
  assign adv       = ce & ~(out_valid & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // One extra bit per operand makes both signednesses a plain signed multiply
  assign a_x    = (A_SIGNED != 0) ? $signed({a_q[A_WIDTH-1], a_q}) : $signed({1'b0, a_q});
  assign b_x    = (B_SIGNED != 0) ? $signed({b_q[B_WIDTH-1], b_q}) : $signed({1'b0, b_q});
  assign a_e    = P'(a_x);
  assign b_e    = P'(b_x);
  assign prod_c = a_e * b_e;

  // Round half up, then arithmetic shift (floor), giving ties toward +inf
  assign rnd_c = $signed({prod_pipe[STAGES-1][P-1], prod_pipe[STAGES-1]}) + RND;
  assign shf_c = rnd_c >>> SHIFT;

`ifdef FOC_MUL_SAT_EN
  // Clamp to the representable output range and flag it
  always_comb begin
    p_c   = shf_c[OUT_WIDTH-1:0];
    sat_c = 1'b0;
    if (OUT_SIGNED) begin
      if (shf_c > S_MAX) begin
        p_c = S_MAX[OUT_WIDTH-1:0]; sat_c = 1'b1;
      end else if (shf_c < S_MIN) begin
        p_c = S_MIN[OUT_WIDTH-1:0]; sat_c = 1'b1;
      end
    end else begin
      if (shf_c < 0) begin
        p_c = '0; sat_c = 1'b1;
      end else if (shf_c > U_MAX) begin
        p_c = U_MAX[OUT_WIDTH-1:0]; sat_c = 1'b1;
      end
    end
  end

  // Count delivered saturated results; clear wins and is not gated by ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if (out_valid && adv && sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_ok;

  // Without clamping the result simply wraps to OUT_WIDTH bits
  always_comb begin
    p_c   = shf_c[OUT_WIDTH-1:0];
    sat_c = 1'b0;
  end

  assign sat_count = '0;
  assign unused_ok = ^{sat_clr, shf_c, S_MAX, S_MIN, U_MAX, OUT_SIGNED};
`endif

  // Whole-pipeline shift on adv: operands, product, delays, final round/clamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      for (int s = 2; s < STAGES; s++) prod_pipe[s] <= '0;
      for (int s = 1; s < STAGES; s++) tag_pipe[s]  <= '0;
      p        <= '0;
      out_tag  <= '0;
      sat      <= 1'b0;
    end else if (adv) begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], in_valid};
      a_q          <= a;
      b_q          <= b;
      tag_pipe[1]  <= in_tag;
      prod_pipe[2] <= prod_c;
      tag_pipe[2]  <= tag_pipe[1];
      for (int s = 3; s < STAGES; s++) begin
        prod_pipe[s] <= prod_pipe[s-1];
        tag_pipe[s]  <= tag_pipe[s-1];
      end
      p       <= p_c;
      out_tag <= tag_pipe[STAGES-1];
      sat     <= sat_c;
    end
  end

endmodule

// File: tb/tb_foc_mul_pipe.sv
// Bench for foc_mul_pipe: two instances (OUT_WIDTH 18 and 16) share stimulus.
// A scoreboard fed by an arithmetic reference model checks every delivered
// result, hold stability and sat_count; directed steps cover the named cases.
module tb_foc_mul_pipe;

`ifdef FOC_MUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sat_clr = 1'b0;
  logic [15:0] a = '0;
  logic [16:0] b = '0;
  logic [3:0]  in_tag = '0;

  logic        rdy18, rdy16, ov18, ov16, s18, s16;
  logic [17:0] p18;
  logic [15:0] p16, cnt18_o, cnt16_o;
  logic [3:0]  t18, t16;

  int compared = 0;
  int mism = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] p18, p16;
    logic        s18, s16;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  foc_mul_pipe #(.OUT_WIDTH(18)) u18 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(rdy18),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(ov18), .out_ready(out_ready),
    .p(p18), .out_tag(t18), .sat(s18), .sat_count(cnt18_o), .sat_clr(sat_clr));

  foc_mul_pipe #(.OUT_WIDTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(rdy16),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(ov16), .out_ready(out_ready),
    .p(p16), .out_tag(t16), .sat(s16), .sat_count(cnt16_o), .sat_clr(sat_clr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, floor((x + 2^14) / 2^15), then clamp or wrap
  function automatic void ref_mul(input logic [15:0] av, input logic [16:0] bv,
                                  input int ow, output logic [63:0] pe, output logic se);
    longint prod, r, lo, hi;
    prod = longint'($signed(av)) * longint'(bv);
    r    = (prod + 64'sd16384) >>> 15;
    lo   = -(64'sd1 <<< (ow-1));
    hi   = (64'sd1 <<< (ow-1)) - 64'sd1;
    se   = 1'b0;
    if (SAT_EN) begin
      if (r > hi) begin r = hi; se = 1'b1; end
      else if (r < lo) begin r = lo; se = 1'b1; end
    end
    pe = 64'(r) & ((64'd1 << ow) - 64'd1);
  endfunction

  // Monitor: scoreboard, hold stability, sat_count model, in_ready rule
  int          cnt18 = 0, cnt16 = 0;
  bit          hold = 0;
  logic [17:0] hp18;
  logic [15:0] hp16;
  logic [3:0]  ht18;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q.delete(); cnt18 = 0; cnt16 = 0; hold = 0;
    end else begin
      chk("sat_count18", 64'(cnt18_o), 64'(cnt18));
      chk("sat_count16", 64'(cnt16_o), 64'(cnt16));
      chk("in_ready16", 64'(rdy16), 64'(ce & ~(ov18 & ~out_ready)));
      if (hold) begin
        chk("hold_valid", 64'(ov18), 64'd1);
        chk("hold_p18", 64'(p18), 64'(hp18));
        chk("hold_p16", 64'(p16), 64'(hp16));
        chk("hold_tag", 64'(t18), 64'(ht18));
      end
      if (ov18 && out_ready && ce) begin
        if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_p18", 64'(p18), e.p18);
          chk("sb_p16", 64'(p16), e.p16);
          chk("sb_sat18", 64'(s18), 64'(e.s18));
          chk("sb_sat16", 64'(s16), 64'(e.s16));
          chk("sb_tag18", 64'(t18), 64'(e.tag));
          chk("sb_tag16", 64'(t16), 64'(e.tag));
          chk("sb_valid16", 64'(ov16), 64'd1);
          if (e.s18 && cnt18 != 65535) cnt18++;
          if (e.s16 && cnt16 != 65535) cnt16++;
        end
      end
      if (sat_clr) begin cnt18 = 0; cnt16 = 0; end
      hold = ov18 && !(out_ready && ce);
      hp18 = p18; hp16 = p16; ht18 = t18;
      if (in_valid && rdy18) begin
        e.tag = in_tag;
        ref_mul(a, b, 18, e.p18, e.s18);
        ref_mul(a, b, 16, e.p16, e.s16);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [16:0] bv, input logic [3:0] tv);
    bit ok = 0;
    in_valid = 1'b1; a = av; b = bv; in_tag = tv;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy18) ok = 1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov18) break;
      n++;
    end
    chk("wait_out_valid", 64'(ov18), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1; ce = 1'b1; in_valid = 1'b0; sat_clr = 1'b0;
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    repeat (2) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n, k;
    // Reset state
    #3;
    chk("rst_valid", 64'(ov18), 64'd0);
    chk("rst_p18", 64'(p18), 64'd0);
    chk("rst_cnt16", 64'(cnt16_o), 64'd0);
    chk("rst_in_ready", 64'(rdy18), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Basic scaling and latency
    send(16'd16384, 17'd65536, 4'h5);
    wait_out(n);
    chk("latency", 64'(n), 64'd3);
    chk("basic_p18", 64'(p18), 64'd32768);
    chk("basic_sat18", 64'(s18), 64'd0);
    chk("basic_tag", 64'(t18), 64'h5);

    // Rounding at OUT_WIDTH 18
    send(16'd1, 17'd16384, 4'h1);  wait_out(n); chk("rnd_half_up", 64'(p18), 64'd1);
    send(16'd1, 17'd16383, 4'h2);  wait_out(n); chk("rnd_below", 64'(p18), 64'd0);
    send(16'hFFFF, 17'd16384, 4'h3); wait_out(n); chk("rnd_neg_tie", 64'(p18), 64'd0);

    // Saturation at OUT_WIDTH 16, starting from a cleared counter
    step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    @(negedge clk); chk("clr_before", 64'(cnt16_o), 64'd0);
    step();
    send(16'h8000, 17'h1FFFF, 4'h6); wait_out(n);
    chk("sat_lo_p16", 64'(p16), SAT_EN ? 64'h8000 : 64'h0001);
    chk("sat_lo_flag", 64'(s16), 64'(SAT_EN));
    @(negedge clk); chk("sat_lo_cnt", 64'(cnt16_o), SAT_EN ? 64'd1 : 64'd0);
    step();
    send(16'h7FFF, 17'h1FFFF, 4'h7); wait_out(n);
    chk("sat_hi_p16", 64'(p16), SAT_EN ? 64'h7FFF : 64'hFFFB);
    chk("sat_hi_flag", 64'(s16), 64'(SAT_EN));
    @(negedge clk); chk("sat_hi_cnt", 64'(cnt16_o), SAT_EN ? 64'd2 : 64'd0);
    step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    @(negedge clk); chk("sat_clr", 64'(cnt16_o), 64'd0);
    step();

    // Backpressure: 10 beats, out_ready low for 3 cycles mid-stream
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      out_ready = !(c >= 5 && c < 8);
      in_valid = 1'b1; in_tag = 4'(k); a = 16'($urandom); b = 17'($urandom);
      @(negedge clk);
      if (c >= 5 && c < 8) chk("bp_in_ready", 64'(rdy18), 64'd0);
      if (rdy18) k++;
      step();
    end
    chk("bp_all_sent", 64'(k), 64'd10);
    drain();

    // ce low for 2 cycles mid-stream
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      ce = !(c == 4 || c == 5);
      in_valid = 1'b1; in_tag = 4'(k + 3); a = 16'($urandom); b = 17'($urandom);
      @(negedge clk);
      if (!ce) chk("ce_in_ready", 64'(rdy18), 64'd0);
      if (rdy18) k++;
      step();
    end
    drain();

    // Randomized traffic with stalls, ce gaps and occasional clears
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 9) != 0);
      sat_clr   = ($urandom_range(0, 40) == 0);
      a = 16'($urandom); b = 17'($urandom); in_tag = 4'($urandom);
      step();
    end
    drain();

    // Reset mid-stream with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h7FFF; b = 17'h1FFFF; in_tag = 4'(i + 9);
      step();
    end
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(ov18), 64'd0);
    chk("mrst_p18", 64'(p18), 64'd0);
    chk("mrst_p16", 64'(p16), 64'd0);
    chk("mrst_tag", 64'(t18), 64'd0);
    chk("mrst_sat", 64'(s16), 64'd0);
    chk("mrst_cnt16", 64'(cnt16_o), 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", 64'(ov18), 64'd0);
    end
    chk("mrst_in_ready", 64'(rdy18), 64'd1);
    step();
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
